// File: rtl/inst_prefetch_queue_pkg.sv
// ============================================================================
// inst_prefetch_queue_pkg : shared types and constants for the fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

package inst_prefetch_queue_pkg;

  localparam int              c_word_w     = 32;
  localparam int              c_ifq_depth  = 4;
  localparam logic [31:0]     c_start_adrs = 32'h0000_1000;

  typedef enum logic [1:0] {
    IFQ_IDLE  = 2'd0,
    IFQ_REQ   = 2'd1,
    IFQ_DRAIN = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [c_word_w-1:0] pc;
    logic [c_word_w-1:0] inst;
  } ifq_entry_t;

  function automatic logic [c_word_w-1:0] word_align(input logic [c_word_w-1:0] adrs);
    return adrs & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_prefetch_queue_if.sv
// ============================================================================
// inst_prefetch_queue_if : redirect, memory fetch and CPU delivery signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface inst_prefetch_queue_if;
  import inst_prefetch_queue_pkg::*;

  logic                redirect;
  logic [c_word_w-1:0] redirect_pc;
  logic                mem_req;
  logic [c_word_w-1:0] mem_adrs;
  logic                mem_ack;
  logic [c_word_w-1:0] mem_rdata;
  logic                inst_valid;
  logic [c_word_w-1:0] inst;
  logic [c_word_w-1:0] inst_pc;
  logic                inst_ready;

  // master is the prefetch queue itself
  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_adrs, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_adrs, inst_valid, inst, inst_pc
  );

endinterface

`default_nettype wire

// File: rtl/inst_prefetch_queue_fifo.sv
// ============================================================================
// inst_prefetch_queue_fifo : first-word-fall-through {pc,inst} queue with flush
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_prefetch_queue_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter  int DEPTH = c_ifq_depth,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk_cpu,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  ifq_entry_t            i_push_data,
  input  wire logic             i_pop,
  input  wire logic             i_flush,
  output ifq_entry_t            o_head,
  output logic                  o_head_valid,
  output logic [CNT_W-1:0]      o_count
);

  ifq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // flush outranks a same-cycle push or pop
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
// ============================================================================
// inst_prefetch_queue : sequential instruction fetcher feeding a flushable queue
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int                  DEPTH      = c_ifq_depth,
  parameter logic [c_word_w-1:0] START_ADRS = c_start_adrs
) (
  input  wire logic              clk_cpu,
  input  wire logic              reset,
  inst_prefetch_queue_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifq_state_t           r_state;
  logic                 r_mem_req;
  logic [c_word_w-1:0]  r_mem_adrs;
  logic [c_word_w-1:0]  r_fpc;

  logic [CNT_W-1:0]     w_count;
  logic                 w_room;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_valid;
  ifq_entry_t           w_head;
  ifq_entry_t           w_push_data;
  logic [c_word_w-1:0]  w_redirect_pc;

  assign w_redirect_pc = word_align(bus.redirect_pc);
  assign w_room        = (w_count < CNT_W'(DEPTH));
  assign w_push        = (r_state == IFQ_REQ) && bus.mem_ack && !bus.redirect;
  assign w_pop         = w_head_valid && bus.inst_ready;
  assign w_push_data   = '{pc: r_fpc, inst: bus.mem_rdata};

  inst_prefetch_queue_fifo #(
    .DEPTH        (DEPTH)
  ) u_fifo (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_flush      (bus.redirect),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  // mem_adrs is only loaded on entry to REQ, so it stays put through REQ and DRAIN
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_state    <= IFQ_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_adrs <= START_ADRS;
      r_fpc      <= START_ADRS;
    end else begin
      if (bus.redirect) begin
        r_fpc <= w_redirect_pc;
      end
      case (r_state)
        IFQ_IDLE: begin
          if (!bus.redirect && w_room) begin
            r_state    <= IFQ_REQ;
            r_mem_req  <= 1'b1;
            r_mem_adrs <= r_fpc;
          end
        end
        IFQ_REQ: begin
          if (bus.mem_ack) begin
            r_state   <= IFQ_IDLE;
            r_mem_req <= 1'b0;
            if (!bus.redirect) begin
              r_fpc <= r_fpc + 32'd4;
            end
          end else if (bus.redirect) begin
            r_state <= IFQ_DRAIN;
          end
        end
        IFQ_DRAIN: begin
          if (bus.mem_ack) begin
            r_state   <= IFQ_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IFQ_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_adrs   = r_mem_adrs;
  assign bus.inst_valid = w_head_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule

`default_nettype wire
